// File: rtl/sar_controller.sv
// ----------------------------------------------------------------------------
// sar_controller
//   Successive-approximation ADC sequencer. It tracks the input for
//   SAMPLE_CYCLES clocks, then resolves one bit per clock from MSB to LSB
//   using the external comparator. It publishes the result with one-cycle
//   ready/data_valid pulses.
//
//   Parameters
//     N_BITS        conversion resolution (4..16)
//     SAMPLE_CYCLES track-phase length in clocks (1..15)
//
//   Ports
//     clk_external  in   system clock, all state changes on its rising edge
//     reset         in   synchronous, active-high reset
//     start         in   conversion request, accepted only in IDLE
//     abort         in   cancel a conversion in SAMPLE or CONVERT
//     comp_out      in   comparator result, 1 means Vin >= Vdac(dac_code)
//     sample_en     out  high while the input is tracked
//     register_clk  out  bit-trial enable, high in every CONVERT cycle
//     dac_code      out  current trial code to the capacitive DAC
//     ready         out  one-cycle end-of-conversion pulse
//     data_out      out  last completed result, held until the next one
//     data_valid    out  one-cycle pulse, data_out updated this cycle
//     busy          out  high in any state other than IDLE
// ----------------------------------------------------------------------------
module sar_controller #(
  parameter int N_BITS        = 8,
  parameter int SAMPLE_CYCLES = 2
) (
  input  logic              clk_external,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              comp_out,
  output logic              sample_en,
  output logic              register_clk,
  output logic [N_BITS-1:0] dac_code,
  output logic              ready,
  output logic [N_BITS-1:0] data_out,
  output logic              data_valid,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, SAMPLE, CONVERT, DONE} state_t;

  localparam int KW = $clog2(N_BITS);
  localparam int CW = 4;
  localparam logic [KW-1:0]     K_MSB    = KW'(N_BITS - 1);
  localparam logic [CW-1:0]     CNT_LAST = CW'(SAMPLE_CYCLES - 1);
  localparam logic [N_BITS-1:0] MSB_ONLY = {1'b1, {(N_BITS-1){1'b0}}};

  state_t            state, state_next;
  logic [KW-1:0]     k, k_next;
  logic [CW-1:0]     cnt, cnt_next;
  logic [N_BITS-1:0] dac_next, data_out_next;
  logic [N_BITS-1:0] bit_mask, resolved;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    // NOTE: default assignment first so no path through the case leaves
    // state_next unassigned, which would infer a latch.
    state_next = state;
    case (state)
      IDLE:    if (start && !abort)            state_next = SAMPLE;
      SAMPLE:  if (abort)                      state_next = IDLE;
               else if (cnt == CNT_LAST)       state_next = CONVERT;
      CONVERT: if (abort)                      state_next = IDLE;
               else if (k == '0)               state_next = DONE;
      DONE:                                    state_next = IDLE;
      default:                                 state_next = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output / datapath next values, decoded from the state being entered so
  // every output can be registered without an extra cycle of latency.
  // --------------------------------------------------------------------------
  always_comb begin
    bit_mask = N_BITS'(1) << k;
    // Resolve the bit under trial: drop it when the DAC overshot Vin.
    resolved = comp_out ? dac_code : (dac_code & ~bit_mask);

    dac_next      = dac_code;
    data_out_next = data_out;
    k_next        = k;
    cnt_next      = cnt;

    case (state_next)
      IDLE: dac_next = '0;
      SAMPLE: begin
        dac_next = '0;
        cnt_next = (state == SAMPLE) ? cnt + 1'b1 : '0;
      end
      CONVERT: begin
        if (state != CONVERT) begin
          dac_next = MSB_ONLY;
          k_next   = K_MSB;
        end else begin
          // Staying in CONVERT implies k > 0, so the next trial bit exists.
          dac_next = resolved | (bit_mask >> 1);
          k_next   = k - 1'b1;
        end
      end
      DONE: begin
        dac_next      = resolved;
        data_out_next = resolved;
      end
      default: dac_next = '0;
    endcase
  end

  // --------------------------------------------------------------------------
  // State and registered outputs
  // --------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before this edge, independent of statement order.
  always_ff @(posedge clk_external) begin
    if (reset) begin
      state        <= IDLE;
      k            <= K_MSB;
      cnt          <= '0;
      dac_code     <= '0;
      data_out     <= '0;
      sample_en    <= 1'b0;
      register_clk <= 1'b0;
      ready        <= 1'b0;
      data_valid   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_next;
      k            <= k_next;
      cnt          <= cnt_next;
      dac_code     <= dac_next;
      data_out     <= data_out_next;
      sample_en    <= (state_next == SAMPLE);
      register_clk <= (state_next == CONVERT);
      ready        <= (state_next == DONE);
      data_valid   <= (state_next == DONE);
      busy         <= (state_next != IDLE);
    end
  end

endmodule

// File: tb/tb_sar_controller.sv
// ----------------------------------------------------------------------------
// tb_sar_controller
//   Directed bench for sar_controller. Two instances are used: the default
//   8-bit / 2-sample-cycle build, and a 12-bit / 1-sample-cycle build. Each
//   instance has an ideal comparator: comp_out = (vin >= dac_code).
//   Edge 0 is the rising edge that samples start. Each observation is taken
//   1 time unit after an edge and is labelled with that edge's number.
// ----------------------------------------------------------------------------
module tb_sar_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // 8-bit instance
  logic       start8, abort8, comp8;
  logic       sample_en8, register_clk8, ready8, data_valid8, busy8;
  logic [7:0] dac8, data_out8, vin8;

  // 12-bit instance
  logic        start12, abort12, comp12;
  logic        sample_en12, register_clk12, ready12, data_valid12, busy12;
  logic [11:0] dac12, data_out12, vin12;

  assign comp8  = (vin8 >= dac8);
  assign comp12 = (vin12 >= dac12);

  sar_controller #(.N_BITS(8), .SAMPLE_CYCLES(2)) dut8 (
    .clk_external (clk),
    .reset        (reset),
    .start        (start8),
    .abort        (abort8),
    .comp_out     (comp8),
    .sample_en    (sample_en8),
    .register_clk (register_clk8),
    .dac_code     (dac8),
    .ready        (ready8),
    .data_out     (data_out8),
    .data_valid   (data_valid8),
    .busy         (busy8)
  );

  sar_controller #(.N_BITS(12), .SAMPLE_CYCLES(1)) dut12 (
    .clk_external (clk),
    .reset        (reset),
    .start        (start12),
    .abort        (abort12),
    .comp_out     (comp12),
    .sample_en    (sample_en12),
    .register_clk (register_clk12),
    .dac_code     (dac12),
    .ready        (ready12),
    .data_out     (data_out12),
    .data_valid   (data_valid12),
    .busy         (busy12)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Observations gathered by run()
  int          rclk_cnt, valid_cnt, ready_cnt, sample_cnt;
  int          valid_at [4];
  logic [15:0] seq [16];

  // Expected DAC trial sequence for Vin = 0xA5 (8 bits).
  logic [7:0] exp_a5 [8] = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    else
      n_pass++;
  endtask

  // Run n_edges clock edges. Bit e of smask/amask gives start/abort as
  // sampled at edge e. Record register_clk cycles, the dac_code seen in each
  // one, and the edges after which data_valid was high.
  task automatic run(input bit wide, input logic [31:0] smask,
                     input logic [31:0] amask, input int n_edges);
    logic rc, dv, rd, se;
    logic [15:0] dc;
    rclk_cnt = 0; valid_cnt = 0; ready_cnt = 0; sample_cnt = 0;
    for (int e = 0; e < n_edges && e < 32; e++) begin
      if (wide) begin start12 = smask[e]; abort12 = amask[e]; end
      else      begin start8  = smask[e]; abort8  = amask[e]; end
      @(posedge clk); #1;
      if (wide) begin
        rc = register_clk12; dv = data_valid12; rd = ready12; se = sample_en12;
        dc = {4'h0, dac12};
      end else begin
        rc = register_clk8; dv = data_valid8; rd = ready8; se = sample_en8;
        dc = {8'h00, dac8};
      end
      if (rc) begin
        if (rclk_cnt < 16) seq[rclk_cnt] = dc;
        rclk_cnt++;
      end
      if (dv) begin
        if (valid_cnt < 4) valid_at[valid_cnt] = e;
        valid_cnt++;
      end
      if (rd) ready_cnt++;
      if (se) sample_cnt++;
    end
    start8 = 1'b0; abort8 = 1'b0; start12 = 1'b0; abort12 = 1'b0;
  endtask

  task automatic check_idle8(input string tag);
    check({tag, " sample_en"},    32'(sample_en8),    0);
    check({tag, " register_clk"}, 32'(register_clk8), 0);
    check({tag, " dac_code"},     32'(dac8),          0);
    check({tag, " busy"},         32'(busy8),         0);
    check({tag, " data_valid"},   32'(data_valid8),   0);
    check({tag, " ready"},        32'(ready8),        0);
  endtask

  initial begin
    reset = 1'b1;
    start8 = 1'b0; abort8 = 1'b0; start12 = 1'b0; abort12 = 1'b0;
    vin8 = 8'h00; vin12 = 12'h000;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    check_idle8("reset");
    check("reset data_out",    32'(data_out8),  0);
    check("reset12 data_out",  32'(data_out12), 0);
    check("reset12 busy",      32'(busy12),     0);
    check("reset12 dac_code",  32'(dac12),      0);
    reset = 1'b0;

    // Vin = 0xA5: full trial sequence, latency 10
    vin8 = 8'hA5;
    run(1'b0, 32'h1, 32'h0, 12);
    check("a5 sample cycles", 32'(sample_cnt), 2);
    check("a5 rclk cycles",   32'(rclk_cnt),   8);
    for (int i = 0; i < 8; i++)
      check($sformatf("a5 trial %0d", i), 32'(seq[i]), 32'(exp_a5[i]));
    check("a5 valid count", 32'(valid_cnt), 1);
    check("a5 valid edge",  32'(valid_at[0]), 10);
    check("a5 ready count", 32'(ready_cnt), 1);
    check("a5 data_out",    32'(data_out8), 32'h0A5);
    check_idle8("a5 after");

    // Extremes of the input range
    vin8 = 8'h00;
    run(1'b0, 32'h1, 32'h0, 12);
    check("zero rclk cycles", 32'(rclk_cnt), 8);
    check("zero valid edge",  32'(valid_at[0]), 10);
    check("zero data_out",    32'(data_out8), 32'h000);

    vin8 = 8'hFF;
    run(1'b0, 32'h1, 32'h0, 12);
    check("full rclk cycles", 32'(rclk_cnt), 8);
    check("full valid edge",  32'(valid_at[0]), 10);
    check("full data_out",    32'(data_out8), 32'h0FF);

    // Abort sampled at the closing edge of the 3rd CONVERT cycle (edge 5)
    vin8 = 8'hA5;
    run(1'b0, 32'h1, 32'h20, 6);
    check_idle8("abort");
    check("abort rclk cycles", 32'(rclk_cnt), 3);
    check("abort data_out",    32'(data_out8), 32'h0FF);
    run(1'b0, 32'h0, 32'h0, 12);
    check("abort no valid",    32'(valid_cnt), 0);
    check("abort data_out kept", 32'(data_out8), 32'h0FF);

    // Abort together with start in IDLE: abort wins
    run(1'b0, 32'h1, 32'h1, 1);
    check("abort+start busy",      32'(busy8),      0);
    check("abort+start sample_en", 32'(sample_en8), 0);

    // Start re-pulsed in SAMPLE (edge 1), CONVERT (edge 5) and DONE (edge 11)
    vin8 = 8'h3C;
    run(1'b0, 32'h823, 32'h0, 24);
    check("ignored-start valid count", 32'(valid_cnt), 1);
    check("ignored-start valid edge",  32'(valid_at[0]), 10);
    check("ignored-start data_out",    32'(data_out8), 32'h03C);
    check("ignored-start busy",        32'(busy8), 0);

    // Abort during DONE is ignored
    vin8 = 8'hC3;
    run(1'b0, 32'h1, 32'h800, 13);
    check("abort-done valid count", 32'(valid_cnt), 1);
    check("abort-done valid edge",  32'(valid_at[0]), 10);
    check("abort-done data_out",    32'(data_out8), 32'h0C3);

    // Held start (edges 0..12): the second conversion starts at edge 12, one
    // IDLE cycle after DONE, so the pulses are 12 edges apart.
    vin8 = 8'h5A;
    run(1'b0, 32'h1FFF, 32'h0, 30);
    check("held valid count", 32'(valid_cnt), 2);
    check("held first edge",  32'(valid_at[0]), 10);
    check("held spacing",     32'(valid_at[1] - valid_at[0]), 12);
    check("held data_out",    32'(data_out8), 32'h05A);

    // Reset in the middle of CONVERT, then a clean conversion
    vin8 = 8'h37;
    run(1'b0, 32'h1, 32'h0, 5);
    check("pre-reset register_clk", 32'(register_clk8), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    check_idle8("mid reset");
    check("mid reset data_out", 32'(data_out8), 0);
    reset = 1'b0;
    run(1'b0, 32'h1, 32'h0, 12);
    check("post-reset valid edge", 32'(valid_at[0]), 10);
    check("post-reset data_out",   32'(data_out8), 32'h037);

    // 12-bit build, one sample cycle: latency 13
    vin12 = 12'h5A3;
    run(1'b1, 32'h1, 32'h0, 16);
    check("w12 sample cycles", 32'(sample_cnt), 1);
    check("w12 rclk cycles",   32'(rclk_cnt), 12);
    check("w12 first trial",   32'(seq[0]), 32'h800);
    check("w12 valid count",   32'(valid_cnt), 1);
    check("w12 valid edge",    32'(valid_at[0]), 13);
    check("w12 data_out",      32'(data_out12), 32'h5A3);
    check("w12 busy after",    32'(busy12), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
